// File: rtl/alu_seq_if.sv
// alu_seq_if
// Groups the valid/ready operation channel and the result/flag channel of the
// sequential ALU into one bundle.
//   master : issues operations (in_valid, op, A, B) and consumes results (out_ready)
//   slave  : the ALU itself; reports in_ready, out_valid, result and compare flags
interface alu_seq_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      op;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            equal;
   logic            lesser_than;
   logic            unsigned_lesser;
   logic            not_equal;
   logic            greater_or_equal;
   logic            unsigned_greater_equal;

   modport master (
      output in_valid, op, A, B, out_ready,
      input  in_ready, out_valid, result, equal, lesser_than, unsigned_lesser,
             not_equal, greater_or_equal, unsigned_greater_equal
   );

   modport slave (
      input  in_valid, op, A, B, out_ready,
      output in_ready, out_valid, result, equal, lesser_than, unsigned_lesser,
             not_equal, greater_or_equal, unsigned_greater_equal
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq
// Multi-cycle execute-stage ALU. Single-cycle ops (add/sub/logic/shift/slt) and
// reserved opcodes finish at the accept edge; MUL/MULHU use a shift-add
// multiplier and DIVU/REMU a restoring divider, one bit per cycle for XLEN
// cycles. Result and branch-compare flags are registered together and held
// until the consumer takes them.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if slave (operation handshake in, result handshake out)
module alu_seq #(
   parameter int XLEN = 64
) (
   input logic     clk,
   input logic     rst_n,
   alu_seq_if.slave bus
);

   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_MULHU = 4'd11;
   localparam logic [3:0] OP_DIVU  = 4'd12;
   localparam logic [3:0] OP_REMU  = 4'd13;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state;
   logic [3:0]        op_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     count;
   logic [XLEN-1:0]   result_q;
   logic [2:0]        flags;
   logic [2:0]        flags_n;

   logic [2:0]        in_flags;
   logic [2:0]        q_flags;
   logic [SW-1:0]     shamt;
   logic [XLEN-1:0]   simple_res;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] div_next;

   // Flags are {equal, signed less, unsigned less}. The signed compare uses the
   // overflow-corrected sign of A-B so that e.g. MIN - 1 still reads as less.
   function automatic logic [2:0] cmp_flags(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [XLEN:0] diff;
      logic          ovf;
      diff = {1'b0, a} - {1'b0, b};
      ovf  = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      return {diff[XLEN-1:0] == '0, diff[XLEN-1] ^ ovf, diff[XLEN]};
   endfunction

   // Single-cycle results and flags, taken straight from the bus at accept.
   always_comb begin
      in_flags   = cmp_flags(bus.A, bus.B);
      shamt      = bus.B[SW-1:0];
      simple_res = '0;
      case (bus.op)
         OP_ADD:  simple_res = bus.A + bus.B;
         OP_SUB:  simple_res = bus.A - bus.B;
         OP_AND:  simple_res = bus.A & bus.B;
         OP_OR:   simple_res = bus.A | bus.B;
         OP_XOR:  simple_res = bus.A ^ bus.B;
         OP_SLL:  simple_res = bus.A << shamt;
         OP_SRL:  simple_res = bus.A >> shamt;
         OP_SRA:  simple_res = $unsigned($signed(bus.A) >>> shamt);
         OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, in_flags[1]};
         OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, in_flags[0]};
         default: simple_res = '0;
      endcase
   end

   // One iteration step of each long operation, working on the latched operands.
   // Multiply: acc = {partial high, remaining multiplier bits}; add A when the
   // current multiplier bit is set, then shift right keeping the carry.
   // Divide: acc = {partial remainder, dividend bits becoming quotient}; shift
   // in the next dividend bit and subtract B when it fits. B == 0 always
   // "fits", which naturally yields an all-ones quotient and remainder = A.
   always_comb begin
      q_flags   = cmp_flags(a_q, b_q);
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
      mul_next  = {mul_sum, acc[XLEN-1:1]};
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      div_rem   = div_ge ? XLEN'(div_shift - {1'b0, b_q}) : div_shift[XLEN-1:0];
      div_next  = {div_rem, acc[XLEN-2:0], div_ge};
   end

   // Main FSM: accept in IDLE, iterate in MUL/DIV, hold the result in DONE
   // until the consumer takes it. Reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         count    <= '0;
         result_q <= '0;
         flags    <= 3'b000;
         flags_n  <= 3'b111;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op_q  <= bus.op;
                  a_q   <= bus.A;
                  b_q   <= bus.B;
                  count <= '0;
                  if (bus.op == OP_MUL || bus.op == OP_MULHU) begin
                     acc   <= {{XLEN{1'b0}}, bus.B};
                     state <= MUL;
                  end else if (bus.op == OP_DIVU || bus.op == OP_REMU) begin
                     acc   <= {{XLEN{1'b0}}, bus.A};
                     state <= DIV;
                  end else begin
                     result_q <= simple_res;
                     flags    <= in_flags;
                     flags_n  <= ~in_flags;
                     state    <= DONE;
                  end
               end
            end
            MUL: begin
               acc   <= mul_next;
               count <= count + 1'b1;
               if (count == LAST) begin
                  result_q <= (op_q == OP_MUL) ? mul_next[XLEN-1:0] : mul_next[2*XLEN-1:XLEN];
                  flags    <= q_flags;
                  flags_n  <= ~q_flags;
                  count    <= '0;
                  state    <= DONE;
               end
            end
            DIV: begin
               acc   <= div_next;
               count <= count + 1'b1;
               if (count == LAST) begin
                  result_q <= (op_q == OP_DIVU) ? div_next[XLEN-1:0] : div_next[2*XLEN-1:XLEN];
                  flags    <= q_flags;
                  flags_n  <= ~q_flags;
                  count    <= '0;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready               = (state == IDLE);
   assign bus.out_valid              = (state == DONE);
   assign bus.result                 = result_q;
   assign bus.equal                  = flags[2];
   assign bus.lesser_than            = flags[1];
   assign bus.unsigned_lesser        = flags[0];
   assign bus.not_equal              = flags_n[2];
   assign bus.greater_or_equal       = flags_n[1];
   assign bus.unsigned_greater_equal = flags_n[0];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
// Directed, table-driven bench for alu_seq at XLEN=64, plus hand-written
// sequences for reset, result hold under back-pressure and reset mid-multiply.
module tb_alu_seq;

   localparam int XLEN  = 64;
   localparam int LIMIT = 200;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic [2:0]  flg;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t vecs[$];

   alu_seq_if #(.XLEN(XLEN)) bus ();

   alu_seq #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare and report one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic [3:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] res, input logic [2:0] flg);
      vec_t v;
      v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg;
      return v;
   endfunction

   // Issue one op, scribble on the inputs while it runs, and measure the number
   // of edges (accept edge included) until out_valid is seen.
   task automatic applyStimulus(input vec_t v, output int lat, output logic busy_ready);
      @(negedge clk);
      checkOutput({v.name, "_in_ready_idle"}, {63'd0, bus.in_ready}, 64'd1);
      bus.op       = v.op;
      bus.A        = v.a;
      bus.B        = v.b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      lat        = 1;
      busy_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (!bus.out_valid && lat < LIMIT) begin
         if (bus.in_ready) busy_ready = 1'b1;
         bus.A        = {$urandom, $urandom};
         bus.B        = {$urandom, $urandom};
         bus.op       = 4'($urandom_range(0, 15));
         bus.in_valid = 1'b1;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   // Hand the result back and confirm the block is ready again one edge later.
   task automatic releaseResult(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput({name, "_release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
   endtask

   task automatic runVector(input vec_t v);
      int   lat;
      logic busy_ready;
      int   exp_lat;
      exp_lat = (v.op >= 4'd10 && v.op <= 4'd13) ? XLEN + 1 : 1;
      applyStimulus(v, lat, busy_ready);
      checkOutput({v.name, "_latency"}, 64'(lat), 64'(exp_lat));
      checkOutput({v.name, "_result"}, bus.result, v.res);
      checkOutput({v.name, "_flags"},
                  {61'd0, bus.equal, bus.lesser_than, bus.unsigned_lesser}, {61'd0, v.flg});
      checkOutput({v.name, "_flags_n"},
                  {61'd0, bus.not_equal, bus.greater_or_equal, bus.unsigned_greater_equal},
                  {61'd0, ~v.flg});
      if (exp_lat > 1) checkOutput({v.name, "_in_ready_busy"}, {63'd0, busy_ready}, 64'd0);
      releaseResult(v.name);
   endtask

   initial begin
      int          lat;
      logic        busy_ready;
      logic        unstable;
      logic        saw_valid;
      logic [63:0] held;

      total = 0;
      bad   = 0;

      // Flags are {equal, signed less, unsigned less}.
      vecs.push_back(mk("add",      4'd0,  64'd5, -64'sd3, 64'd2, 3'b001));
      vecs.push_back(mk("sub_ovf",  4'd1,  MINV, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010));
      vecs.push_back(mk("sub_ovf2", 4'd1,  64'h7FFF_FFFF_FFFF_FFFF, MINV, ALL1, 3'b001));
      vecs.push_back(mk("sub_neg",  4'd1,  64'd0, 64'd1, ALL1, 3'b011));
      vecs.push_back(mk("sra",      4'd7,  64'hF000_0000_0000_0000, 64'h44, 64'hFF00_0000_0000_0000, 3'b010));
      vecs.push_back(mk("srl",      4'd6,  64'hF000_0000_0000_0000, 64'h44, 64'h0F00_0000_0000_0000, 3'b010));
      vecs.push_back(mk("sra63",    4'd7,  MINV, 64'h7F, ALL1, 3'b010));
      vecs.push_back(mk("sll63",    4'd5,  64'd1, 64'h7F, MINV, 3'b011));
      vecs.push_back(mk("slt",      4'd8,  ALL1, 64'd0, 64'd1, 3'b010));
      vecs.push_back(mk("sltu",     4'd9,  ALL1, 64'd0, 64'd0, 3'b010));
      vecs.push_back(mk("and",      4'd2,  64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F00_0F00_0F00_0F00, 3'b010));
      vecs.push_back(mk("or",       4'd3,  64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFF0F_FF0F_FF0F_FF0F, 3'b010));
      vecs.push_back(mk("xor",      4'd4,  64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF00F_F00F_F00F_F00F, 3'b010));
      vecs.push_back(mk("add_eq",   4'd0,  64'd7, 64'd7, 64'd14, 3'b100));
      vecs.push_back(mk("reserved", 4'd15, 64'd3, 64'd9, 64'd0, 3'b011));
      vecs.push_back(mk("mul",      4'd10, ALL1, ALL1, 64'd1, 3'b100));
      vecs.push_back(mk("mulhu",    4'd11, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b100));
      vecs.push_back(mk("mul_dec",  4'd10, 64'd123456789, 64'd1000, 64'd123456789000, 3'b000));
      vecs.push_back(mk("mulhu_2",  4'd11, MINV, 64'd4, 64'd2, 3'b010));
      vecs.push_back(mk("divu",     4'd12, 64'd100, 64'd7, 64'd14, 3'b000));
      vecs.push_back(mk("remu",     4'd13, 64'd100, 64'd7, 64'd2, 3'b000));
      vecs.push_back(mk("divu_z",   4'd12, 64'd100, 64'd0, ALL1, 3'b000));
      vecs.push_back(mk("remu_z",   4'd13, 64'd100, 64'd0, 64'd100, 3'b000));

      // Reset values, then release reset.
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 4'd0;
      bus.A         = '0;
      bus.B         = '0;
      bus.out_ready = 1'b0;
      #12;
      checkOutput("reset_result", bus.result, 64'd0);
      checkOutput("reset_flags",
                  {58'd0, bus.equal, bus.lesser_than, bus.unsigned_lesser,
                   bus.not_equal, bus.greater_or_equal, bus.unsigned_greater_equal},
                  64'b000111);
      checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

      foreach (vecs[i]) runVector(vecs[i]);

      // Back-pressure: result must hold while out_ready stays low.
      applyStimulus(mk("hold", 4'd0, 64'h1234, 64'h1111, 64'h2345, 3'b000), lat, busy_ready);
      checkOutput("hold_result", bus.result, 64'h2345);
      held     = bus.result;
      unstable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.result !== held || !bus.out_valid || bus.in_ready) unstable = 1'b1;
      end
      checkOutput("hold_stable", {63'd0, unstable}, 64'd0);
      releaseResult("hold");

      // Reset at iteration 30 of a multiply aborts it.
      @(negedge clk);
      bus.op       = 4'd10;
      bus.A        = ALL1;
      bus.B        = ALL1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_result", bus.result, 64'd0);
      checkOutput("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.out_valid) saw_valid = 1'b1;
      end
      checkOutput("abort_no_valid", {63'd0, saw_valid}, 64'd0);
      checkOutput("abort_result_after", bus.result, 64'd0);
      runVector(mk("post_abort", 4'd12, 64'd100, 64'd7, 64'd14, 3'b000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. It supports the full RV base integer operation set plus unsigned multiply and divide, over an XLEN-wide datapath. Simple operations complete in one cycle; multiply and divide run as iterative state machines. The block sits in the execute stage behind a valid/ready handshake, so the control unit can stall on long operations. Branch-compare flags (equal, signed/unsigned less-than) are registered with every result.

## Interface
- XLEN, 64, operand/result width in bits; legal values are powers of two from 8 to 64.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op are valid this cycle
- in_ready  out  1  block can accept an operation; high only in IDLE
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU, 14–15 reserved
- A  in  XLEN  operand 1
- B  in  XLEN  operand 2
- out_valid  out  1  result and flags valid; held until out_ready
- out_ready  in  1  consumer takes the result
- result  out  XLEN  registered result
- equal  out  1  A == B
- lesser_than  out  1  signed A < B
- unsigned_lesser  out  1  unsigned A < B
- not_equal, greater_or_equal, unsigned_greater_equal  out  1 each  registered complements of the three flags above

## Operation
- States: IDLE, MUL, DIV, DONE. Accept happens on a clock edge where in_valid && in_ready; A, B and op are latched at that edge.
- Flags are computed from the latched A and B, whatever the op. They are derived from A−B with full overflow-correct signed compare, not from the raw sign bit of the difference. Flags update in the same cycle as result.
- IDLE → DONE for ops 0–9 and 14–15. Result is written at the accept edge.
- ADD/SUB wrap modulo 2^XLEN. Shifts use B[log2(XLEN)−1:0] only; SRA sign-fills. SLT/SLTU produce a zero-extended 0 or 1.
- Reserved ops produce result 0, with flags still computed.
- IDLE → MUL for ops 10–11. Shift-add, one bit of B per cycle, 2·XLEN-bit accumulator.
  - MUL returns the low XLEN bits.
  - MULHU returns the high XLEN bits.
- IDLE → DIV for ops 12–13. Restoring divider, one quotient bit per cycle.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divide by zero: quotient = all ones, remainder = A. No exception is raised, and the full iteration count is still spent.
- Iteration counter is log2(XLEN)+1 bits wide and counts from 0 to XLEN−1. MUL/DIV → DONE when the counter reaches XLEN−1; the final result is written on that edge.
- DONE: out_valid = 1. result and flags stay stable until out_ready is high at an edge, then the block returns to IDLE.
- in_ready = (state == IDLE). A new op is never accepted in DONE, even when out_ready is high in the same cycle, so there is a one-cycle bubble between back-to-back ops.
- in_valid while busy is ignored, and the input is not queued.

## Timing
- Reset, asynchronous, any state: state = IDLE, result = 0, equal/lesser_than/unsigned_lesser = 0, complements = 1, out_valid = 0, counter = 0. in_ready = 1 once rst_n is high.
- Reset asserted mid-MUL/DIV aborts the operation. No out_valid is produced for it, and partial accumulators are cleared.
- Simple op: accept at edge N, out_valid high from N+1.
- MUL/DIV: accept at edge N, out_valid high from N+XLEN+1.
- out_valid falls on the edge after out_ready is sampled high. The earliest next accept is one cycle later.
- If out_ready is held low indefinitely, result and flags hold their values; there is no timeout.
- op, A and B are don't-care outside the accept edge. Changing them mid-operation must not affect the result.

## Test plan
- Reset then ADD (XLEN=64): A=5, B=−3, op=0 → out_valid one cycle after accept, result=2, equal=0, lesser_than=0, unsigned_lesser=1 (5 < 0xFFFF…FFFD).
- Signed overflow compare: A=0x8000…0000, B=1, op=1 → result=0x7FFF…FFFF, lesser_than=1, unsigned_lesser=0, greater_or_equal=0.
- Shift and logic sweep:
  - A=0xF000…0000, B=0x44, op=7 → result=0xFF00…0000 (shamt 4).
  - op=6 → 0x0F00…0000.
  - op=8 with A=−1, B=0 → result=1.
- MUL/MULHU: A=B=0xFFFF…FFFF.
  - op=10 → result=1, out_valid exactly 65 cycles after accept.
  - op=11 → result=0xFFFF…FFFE.
  - in_ready must stay low throughout the operation.
- DIVU/REMU:
  - A=100, B=7 → quotient 14, remainder 2.
  - B=0 → DIVU gives all ones, REMU gives 100.
  - Changing A and B during iteration does not alter the result.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles with result stable, then pulse it → out_valid drops and in_ready rises on the next cycle.
  - Assert rst_n=0 at iteration 30 of a MUL → out_valid never rises and result=0. The next op after reset completes correctly.
